stb_gen_ctrl: RTL and testbench

//  Sequencer for one stb_gen measure channel: on start, resets the generator, runs period detection,

---
 rtl/stb_gen_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_stb_gen_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stb_gen_ctrl.sv
// Sequencer for one stb_gen measure channel: reset, period detect, lock, N strobe captures with min/max; optional sum under STB_GEN_CTRL_AVG_EN.
// Capture visible one cycle after stb_valid_i; no backpressure (stb_gen is paced one request at a time, abort preempts everything).
module stb_gen_ctrl #(
  parameter int T_CNT_WIDTH    = 32,
  parameter int N_W            = 16,
  parameter int RST_CYCLES     = 4,
  parameter int RUN_DET_CYCLES = 42,
  parameter int RDY_TIMEOUT    = 1048576,
  parameter int STB_TIMEOUT    = 1048576
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [N_W-1:0]         n_stb_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic                   gen_rst_o,
  output logic                   run_det_o,
  input  logic                   gen_rdy_i,
  input  logic                   gen_err_i,
  output logic                   stb_req_o,
  input  logic                   stb_valid_i,
  input  logic [T_CNT_WIDTH-1:0] stb_period_i,
  output logic [T_CNT_WIDTH-1:0] period_o,
  output logic [T_CNT_WIDTH-1:0] period_min_o,
  output logic [T_CNT_WIDTH-1:0] period_max_o,
  output logic [N_W-1:0]         stb_cnt_o
`ifdef STB_GEN_CTRL_AVG_EN
  ,
  output logic [T_CNT_WIDTH+N_W-1:0] period_sum_o
`endif
);

  localparam int TMAX_A = (RST_CYCLES > RUN_DET_CYCLES) ? RST_CYCLES : RUN_DET_CYCLES;
  localparam int TMAX_B = (RDY_TIMEOUT > STB_TIMEOUT) ? RDY_TIMEOUT : STB_TIMEOUT;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TMR_W  = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, GEN_RST, RUN_DET, WAIT_RDY, REQ, WAIT_VALID, DONE, ERR
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [N_W-1:0]   n_stb_q;
  logic [N_W-1:0]   cnt_inc;
  logic             accept, capture, err_set, done_nxt;
  logic [1:0]       err_code_nxt;

  assign busy_o    = (state == GEN_RST) || (state == RUN_DET) || (state == WAIT_RDY) ||
                     (state == REQ) || (state == WAIT_VALID);
  assign gen_rst_o = (state == GEN_RST);
  assign run_det_o = (state == RUN_DET);
  assign stb_req_o = (state == REQ);
  assign cnt_inc   = (&stb_cnt_o) ? stb_cnt_o : stb_cnt_o + 1'b1;

  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    accept       = 1'b0;
    capture      = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 2'b00;
    done_nxt     = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_nxt = GEN_RST;
          tmr_nxt   = TMR_W'(RST_CYCLES - 1);
          accept    = 1'b1;
        end
      end
      GEN_RST: begin
        if (tmr == '0) begin
          state_nxt = RUN_DET;
          tmr_nxt   = TMR_W'(RUN_DET_CYCLES - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      RUN_DET: begin
        if (tmr == '0) begin
          state_nxt = WAIT_RDY;
          tmr_nxt   = TMR_W'(RDY_TIMEOUT - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      WAIT_RDY: begin
        if (gen_err_i) begin
          state_nxt = ERR; err_set = 1'b1; err_code_nxt = 2'b11; tmr_nxt = '0;
        end else if (gen_rdy_i) begin
          state_nxt = REQ; tmr_nxt = '0;
        end else if (tmr == '0) begin
          state_nxt = ERR; err_set = 1'b1; err_code_nxt = 2'b01;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      REQ: begin
        if (gen_err_i) begin
          state_nxt = ERR; err_set = 1'b1; err_code_nxt = 2'b11; tmr_nxt = '0;
        end else begin
          state_nxt = WAIT_VALID;
          tmr_nxt   = TMR_W'(STB_TIMEOUT - 1);
        end
      end
      WAIT_VALID: begin
        if (gen_err_i) begin
          state_nxt = ERR; err_set = 1'b1; err_code_nxt = 2'b11; tmr_nxt = '0;
        end else if (stb_valid_i) begin
          capture = 1'b1;
          tmr_nxt = '0;
          if ((n_stb_q != '0) && (cnt_inc == n_stb_q)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end else if (tmr == '0) begin
          state_nxt = ERR; err_set = 1'b1; err_code_nxt = 2'b10;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: ;
    endcase
    // Abort overrides every event decided above, including a same-cycle capture.
    if (abort_i && busy_o) begin
      state_nxt = IDLE;
      tmr_nxt   = '0;
      capture   = 1'b0;
      err_set   = 1'b0;
      done_nxt  = 1'b0;
    end
  end

`ifdef STB_GEN_CTRL_AVG_EN
  logic [T_CNT_WIDTH+N_W:0] sum_add;
  assign sum_add = {1'b0, period_sum_o} + (T_CNT_WIDTH+N_W+1)'(stb_period_i);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tmr          <= '0;
      n_stb_q      <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= 2'b00;
      period_o     <= '0;
      period_min_o <= '1;
      period_max_o <= '0;
      stb_cnt_o    <= '0;
`ifdef STB_GEN_CTRL_AVG_EN
      period_sum_o <= '0;
`endif
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      done_o <= done_nxt;
      if (accept) begin
        n_stb_q      <= n_stb_i;
        err_o        <= 1'b0;
        err_code_o   <= 2'b00;
        period_o     <= '0;
        period_min_o <= '1;
        period_max_o <= '0;
        stb_cnt_o    <= '0;
`ifdef STB_GEN_CTRL_AVG_EN
        period_sum_o <= '0;
`endif
      end
      if (err_set) begin
        err_o      <= 1'b1;
        err_code_o <= err_code_nxt;
      end
      if (capture) begin
        period_o  <= stb_period_i;
        stb_cnt_o <= cnt_inc;
        if (stb_period_i < period_min_o) period_min_o <= stb_period_i;
        if (stb_period_i > period_max_o) period_max_o <= stb_period_i;
`ifdef STB_GEN_CTRL_AVG_EN
        period_sum_o <= sum_add[T_CNT_WIDTH+N_W] ? '1 : sum_add[T_CNT_WIDTH+N_W-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_stb_gen_ctrl.sv
// Directed bench for stb_gen_ctrl: main instance (long rdy timeout) plus a second instance with RDY_TIMEOUT=64.
module tb_stb_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, gen_rdy, gen_err, stb_valid;
  logic [15:0] n_stb;
  logic [31:0] stb_period;
  logic        busy, done, err, gen_rst, run_det, stb_req;
  logic [1:0]  err_code;
  logic [31:0] period, period_min, period_max;
  logic [15:0] stb_cnt;
`ifdef STB_GEN_CTRL_AVG_EN
  logic [47:0] period_sum;
`endif

  logic        rto_start;
  logic        rto_busy, rto_done, rto_err, rto_gen_rst, rto_run_det, rto_req;
  logic [1:0]  rto_code;
  logic [31:0] rto_period, rto_min, rto_max;
  logic [15:0] rto_cnt;
`ifdef STB_GEN_CTRL_AVG_EN
  logic [47:0] rto_sum;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stb_gen_ctrl #(.T_CNT_WIDTH(32), .N_W(16), .RST_CYCLES(4), .RUN_DET_CYCLES(42),
                 .RDY_TIMEOUT(200), .STB_TIMEOUT(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .n_stb_i(n_stb),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
    .gen_rst_o(gen_rst), .run_det_o(run_det), .gen_rdy_i(gen_rdy), .gen_err_i(gen_err),
    .stb_req_o(stb_req), .stb_valid_i(stb_valid), .stb_period_i(stb_period),
    .period_o(period), .period_min_o(period_min), .period_max_o(period_max),
    .stb_cnt_o(stb_cnt)
`ifdef STB_GEN_CTRL_AVG_EN
    , .period_sum_o(period_sum)
`endif
  );

  stb_gen_ctrl #(.T_CNT_WIDTH(32), .N_W(16), .RST_CYCLES(4), .RUN_DET_CYCLES(42),
                 .RDY_TIMEOUT(64), .STB_TIMEOUT(32)) u_rto (
    .clk_i(clk), .rst_i(rst), .start_i(rto_start), .abort_i(1'b0), .n_stb_i(16'd0),
    .busy_o(rto_busy), .done_o(rto_done), .err_o(rto_err), .err_code_o(rto_code),
    .gen_rst_o(rto_gen_rst), .run_det_o(rto_run_det), .gen_rdy_i(1'b0), .gen_err_i(1'b0),
    .stb_req_o(rto_req), .stb_valid_i(1'b0), .stb_period_i(32'd0),
    .period_o(rto_period), .period_min_o(rto_min), .period_max_o(rto_max),
    .stb_cnt_o(rto_cnt)
`ifdef STB_GEN_CTRL_AVG_EN
    , .period_sum_o(rto_sum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int w = 0;
    while (!stb_req && w < 200) begin
      step();
      w++;
    end
    check("req_seen", stb_req, 1);
  endtask

  task automatic serve(input logic [31:0] p);
    wait_req();
    step();
    stb_valid  = 1'b1;
    stb_period = p;
    step();
    stb_valid  = 1'b0;
    stb_period = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_gen_rst"}, gen_rst, 0);
    check({tag, "_run_det"}, run_det, 0);
    check({tag, "_req"}, stb_req, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_min"}, period_min, 64'hFFFF_FFFF);
    check({tag, "_max"}, period_max, 0);
    check({tag, "_cnt"}, stb_cnt, 0);
  endtask

  logic [31:0] t1_p [4]  = '{32'd2500, 32'd2501, 32'd2499, 32'd2500};
  logic [31:0] t5_p [10] = '{32'd505, 32'd503, 32'd509, 32'd500, 32'd507,
                             32'd501, 32'd506, 32'd502, 32'd508, 32'd504};

  initial begin
    int c;
    logic seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; gen_rdy = 1'b0; gen_err = 1'b0;
    stb_valid = 1'b0; stb_period = '0; n_stb = '0; rto_start = 1'b0;
    step(); step();
    rst = 1'b0;
    check_reset("rst");
    check("rto_rst_min", rto_min, 64'hFFFF_FFFF);

    // 1: basic run, n_stb=4
    start = 1'b1; n_stb = 16'd4;
    step();
    start = 1'b0;
    c = 0;
    while (gen_rst && c < 100) begin c++; step(); end
    check("t1_gen_rst_cycles", c, 4);
    c = 0;
    while (run_det && c < 100) begin c++; step(); end
    check("t1_run_det_cycles", c, 42);
    seen = 1'b0;
    repeat (100) begin
      if (stb_req || err) seen = 1'b1;
      step();
    end
    check("t1_quiet_before_rdy", seen, 0);
    gen_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(t1_p[i]);
      check($sformatf("t1_done_%0d", i), done, (i == 3) ? 1 : 0);
      if (i < 3) check($sformatf("t1_req_lat_%0d", i), stb_req, 1);
    end
    check("t1_min", period_min, 2499);
    check("t1_max", period_max, 2501);
    check("t1_period", period, 2500);
    check("t1_cnt", stb_cnt, 4);
    check("t1_busy", busy, 0);
`ifdef STB_GEN_CTRL_AVG_EN
    check("t1_sum", period_sum, 10000);
`endif
    step();
    check("t1_done_pulse_end", done, 0);

    // 2: rdy timeout on the second instance
    rto_start = 1'b1;
    step();
    rto_start = 1'b0;
    repeat (46) step();
    check("t2_busy_wait_rdy", rto_busy, 1);
    seen = 1'b0;
    repeat (63) begin
      step();
      if (rto_req || rto_err) seen = 1'b1;
    end
    check("t2_no_err_early", seen, 0);
    step();
    check("t2_err", rto_err, 1);
    check("t2_code", rto_code, 2'b01);
    check("t2_busy", rto_busy, 0);
    check("t2_no_req", rto_req, 0);

    // 3: strobe timeout after two captures
    start = 1'b1; n_stb = 16'd5;
    step();
    start = 1'b0;
    serve(32'd100);
    serve(32'd200);
    c = 0;
    while (!err && c < 100) begin step(); c++; end
    check("t3_timeout_cycles", c, 33);
    check("t3_code", err_code, 2'b10);
    check("t3_cnt", stb_cnt, 2);
    check("t3_busy", busy, 0);
    start = 1'b1; n_stb = 16'd3;
    step();
    start = 1'b0;
    check("t3_err_cleared", err, 0);
    check("t3_code_cleared", err_code, 0);
    check("t3_cnt_cleared", stb_cnt, 0);
    check("t3_busy_restart", busy, 1);

    // 4: gen_err with a same-cycle valid discards that period
    serve(32'd300);
    wait_req();
    step();
    stb_valid = 1'b1; stb_period = 32'd777; gen_err = 1'b1;
    step();
    stb_valid = 1'b0; stb_period = '0; gen_err = 1'b0;
    check("t4_err", err, 1);
    check("t4_code", err_code, 2'b11);
    check("t4_period", period, 300);
    check("t4_cnt", stb_cnt, 1);

    // 5: continuous mode then abort
    start = 1'b1; n_stb = 16'd0;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      serve(t5_p[i]);
      if (done) seen = 1'b1;
    end
    check("t5_no_done", seen, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_cnt", stb_cnt, 10);
    check("t5_done", done, 0);
    check("t5_err", err, 0);
    check("t5_period", period, 504);
    check("t5_min", period_min, 500);
    check("t5_max", period_max, 509);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_idle_abort_busy", busy, 0);
    check("t5_idle_abort_cnt", stb_cnt, 10);

    // 6: start beats abort in IDLE; start while busy ignored; rst mid-run
    start = 1'b1; abort = 1'b1; n_stb = 16'd2;
    step();
    start = 1'b0; abort = 1'b0;
    check("t6_start_wins", gen_rst, 1);
    wait_req();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_start_busy_gen_rst", gen_rst, 0);
    check("t6_start_busy_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
